// File: rtl/fire_layer_sequencer.sv
// Runs squeeze -> expand1 -> expand3 in turn, streaming each layer's samples
// into the writeback RAM and trapping short, long or hung layers in ERR.
module fire_layer_sequencer #(
    parameter int SAMPLES    = 256,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_CYCLES = 1048576,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        layer_sample,
    input  logic [2:0]        layer_finish,
    input  logic              ram_ready,
    output logic [2:0]        layer_en,
    output logic [2:0]        ram_feedback,
    output logic              wr_req,
    output logic [ADDR_W+1:0] wr_addr,
    output logic [1:0]        cur_layer,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int WD_W  = $clog2(MAX_CYCLES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, RUN, ACK, GAP, DONE, ERR} state_t;

    state_t            state, state_n;
    logic [1:0]        layer_q, layer_n;
    logic [CNT_W-1:0]  count, count_n, count_upd;
    logic [WD_W-1:0]   wd, wd_n, wd_upd;
    logic [GAP_W-1:0]  gap, gap_n;
    logic              wr_vld_p1, wr_vld_n;
    logic [ADDR_W+1:0] wr_addr_p1, wr_addr_n;
    logic              smp, fin, overrun, leave_gap;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WD_W-1:0] sat_inc_wd(input logic [WD_W-1:0] v);
        return (&v) ? v : v + WD_W'(1);
    endfunction

    always_comb begin
        state_n   = state;
        layer_n   = layer_q;
        count_n   = count;
        wd_n      = wd;
        gap_n     = gap;
        wr_vld_n  = 1'b0;
        wr_addr_n = wr_addr_p1;
        smp       = layer_sample[layer_q];
        fin       = layer_finish[layer_q];
        overrun   = 1'b0;
        leave_gap = 1'b0;
        count_upd = count;
        wd_upd    = sat_inc_wd(wd);

        case (state)
            IDLE: begin
                if (start) begin
                    layer_n = 2'd0;
                    count_n = '0;
                    wd_n    = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                wd_n = wd_upd;
                // A sample is folded into the count before any finish in the same cycle is judged
                if (smp) begin
                    if (count >= CNT_W'(SAMPLES)) begin
                        overrun = 1'b1;
                    end else begin
                        count_upd = sat_inc_cnt(count);
                        wr_vld_n  = 1'b1;
                        wr_addr_n = {layer_q, count[ADDR_W-1:0]};
                    end
                end
                count_n = count_upd;
                if (overrun || wd_upd >= WD_W'(MAX_CYCLES)) begin
                    state_n = ERR;
                end else if (fin) begin
                    state_n = (count_upd == CNT_W'(SAMPLES)) ? ACK : ERR;
                end
            end
            ACK: begin
                gap_n = '0;
                if (GAP_CYCLES == 0) leave_gap = 1'b1;
                else                 state_n   = GAP;
            end
            GAP: begin
                if (gap >= GAP_W'(GAP_CYCLES - 1)) leave_gap = 1'b1;
                else                               gap_n     = gap + GAP_W'(1);
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = ERR;
            default: state_n = IDLE;
        endcase

        if (leave_gap) begin
            if (layer_q < 2'd2) begin
                layer_n = layer_q + 2'd1;
                count_n = '0;
                wd_n    = '0;
                state_n = RUN;
            end else begin
                state_n = DONE;
            end
        end
    end

    // p1: write strobe and address registered one cycle after the sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            layer_q    <= 2'd0;
            count      <= '0;
            wd         <= '0;
            gap        <= '0;
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
        end else begin
            state      <= state_n;
            layer_q    <= layer_n;
            count      <= count_n;
            wd         <= wd_n;
            gap        <= gap_n;
            wr_vld_p1  <= wr_vld_n;
            wr_addr_p1 <= wr_addr_n;
        end
    end

    assign layer_en     = (state == RUN) ? (3'(ram_ready) << layer_q) : 3'b000;
    assign ram_feedback = (state == ACK) ? (3'b001 << layer_q) : 3'b000;
    assign wr_req       = wr_vld_p1 & (state != ERR);
    assign wr_addr      = wr_addr_p1;
    assign cur_layer    = layer_q;
    assign busy         = (state == RUN) || (state == ACK) || (state == GAP) || (state == DONE);
    assign done         = (state == DONE);
    assign error        = (state == ERR);

endmodule
